ex_div: RTL
===========

EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low, ports clk and rst.
REQ-002 clk  input  1  rising-edge clock shared with the pipeline registers.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 div_start  input  1  execute stage holds an M-extension divide/remainder instruction.
REQ-005 div_op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 op1  input  32  dividend from the execute-stage operand register.
REQ-007 op2  input  32  divisor from the execute-stage operand register.
REQ-008 rd_addr  input  5  destination register of the divide instruction.
REQ-009 flush  input  1  synchronous kill from a taken jump/branch.
REQ-010 busy  output  1  stall request to hold the PC, if_id and id_ex.
REQ-011 result  output  32  quotient or remainder.
REQ-012 result_valid  output  1  result is valid this cycle.
REQ-013 rd_addr_o  output  5  destination register for write-back.
REQ-014 rd_wen_o  output  1  register write enable; equals result_valid.

Function
REQ-015 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-016 In IDLE with div_start=1 and flush=0, the block SHALL latch op1, op2, div_op and rd_addr at the clock edge; later changes to these inputs SHALL be ignored until the next accept.
REQ-017 Special case, divisor zero or signed overflow: the block SHALL go from IDLE straight to DONE, so the result is valid in the cycle after the start cycle.
REQ-018 Otherwise the block SHALL go from IDLE to CALC, with the 5-bit iteration counter cleared to 0.
REQ-019 CALC SHALL run a radix-2 restoring division, one quotient bit per cycle, for exactly 32 cycles; the counter wraps 31->0 on the transition to DONE.
REQ-020 Normal latency: start in cycle 1, CALC in cycles 2-33, DONE in cycle 34.
REQ-021 DONE SHALL last exactly one cycle and then return to IDLE; div_start in DONE SHALL be ignored.
REQ-022 Formula: busy = (IDLE & div_start & ~flush) | CALC; busy SHALL be 0 in DONE so the pipeline advances with the result.
REQ-023 In DONE: result_valid=1, rd_wen_o=1, rd_addr_o=latched rd_addr. In all other states: result_valid=0, rd_wen_o=0.
REQ-024 Signed ops (DIV/REM) SHALL divide magnitudes, then apply signs:
- quotient is negated when the operand signs differ;
- remainder takes the dividend's sign.
REQ-025 Divide by zero: quotient 0xFFFFFFFF for DIV and DIVU; remainder equals the latched dividend for REM and REMU.
REQ-026 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
REQ-027 flush=1 in any state SHALL force IDLE at the next edge:
- no result_valid is produced;
- busy falls in the next cycle;
- flush wins over a simultaneous div_start.
REQ-028 result SHALL hold its last value outside DONE; only result_valid qualifies it.
REQ-029 Unsigned ops (DIVU/REMU) SHALL treat both operands as 32-bit unsigned; all arithmetic is 32-bit, with a 33-bit partial remainder internally.

Reset
REQ-030 rst=0 SHALL asynchronously force:
- state IDLE and counter 0;
- busy=0, result=0, result_valid=0, rd_addr_o=0, rd_wen_o=0.
REQ-031 Reset asserted mid-CALC SHALL abort the operation with no result; after release, a new div_start SHALL be accepted normally.

Verification
REQ-032 DIVU op1=100, op2=7, start in cycle 1 -> busy=1 in cycles 1-33, result=14 with result_valid=1 in cycle 34 only.
REQ-033 REM op1=0xFFFFFFF9 (-7), op2=2 -> result=0xFFFFFFFF (-1) in cycle 34; DIV with the same operands -> 0xFFFFFFFD (-3).
REQ-034 DIV op1=5, op2=0 -> result=0xFFFFFFFF in cycle 2; REMU op1=5, op2=0 -> result=5 in cycle 2.
REQ-035 DIV op1=0x80000000, op2=0xFFFFFFFF -> result=0x80000000 in cycle 2; REM with the same operands -> result=0.
REQ-036 DIVU start, then flush=1 in cycle 10 -> busy=0 from cycle 11, no result_valid; a new DIVU 9/3 started in cycle 12 -> result=3 in cycle 45.
REQ-037 rst=0 pulsed in cycle 15 of a DIV -> all outputs 0 immediately (asynchronously); no result_valid follows.

Source files
------------

// File: rtl/ex_div_if.sv
// Divider handshake bundle between the execute stage and the M-extension
// divide unit. The pipeline side drives the request fields and the divider
// answers with the stall request and the write-back fields.
interface ex_div_if;
   logic        div_start;
   logic [1:0]  div_op;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [4:0]  rd_addr;
   logic        flush;
   logic        busy;
   logic [31:0] result;
   logic        result_valid;
   logic [4:0]  rd_addr_o;
   logic        rd_wen_o;

   modport master (
      output div_start, div_op, op1, op2, rd_addr, flush,
      input  busy, result, result_valid, rd_addr_o, rd_wen_o
   );

   modport slave (
      input  div_start, div_op, op1, op2, rd_addr, flush,
      output busy, result, result_valid, rd_addr_o, rd_wen_o
   );
endinterface

// File: rtl/ex_div.sv
// Multi-cycle RISC-V DIV/DIVU/REM/REMU unit for the execute stage.
// Radix-2 restoring division on operand magnitudes, 32 iterations, with
// signs applied on the last iteration. Divide-by-zero and signed overflow
// bypass the iterations and answer in the cycle after the start cycle.
module ex_div (
   input  logic     clk,
   input  logic     rst,
   ex_div_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state;
   state_t      state_next;

   logic [4:0]  count;
   logic [31:0] divisor;
   logic [31:0] quo;
   logic [31:0] rem;
   logic        is_rem;
   logic        neg_q;
   logic        neg_r;
   logic [4:0]  rd_q;
   logic [31:0] result_q;

   logic        is_signed;
   logic        start_ok;
   logic        div_zero;
   logic        overflow;
   logic        special;
   logic [31:0] special_result;
   logic [31:0] op1_mag;
   logic [31:0] op2_mag;

   logic [32:0] shifted;
   logic [32:0] diff;
   logic        fits;
   logic [31:0] rem_next;
   logic [31:0] quo_next;
   logic [31:0] q_final;
   logic [31:0] r_final;

   logic        busy_c;
   logic        valid_c;

   // DIV and REM are the signed ops (funct3 bit 0 clear).
   assign is_signed = ~bus.div_op[0];
   assign start_ok  = (state == IDLE) & bus.div_start & ~bus.flush;
   assign div_zero  = (bus.op2 == 32'h0000_0000);
   assign overflow  = is_signed & (bus.op1 == 32'h8000_0000) & (bus.op2 == 32'hFFFF_FFFF);
   assign special   = div_zero | overflow;

   // Divide by zero: all-ones quotient or the dividend as remainder.
   // Signed overflow: the dividend as quotient or zero remainder.
   assign special_result = div_zero ? (bus.div_op[1] ? bus.op1 : 32'hFFFF_FFFF)
                                    : (bus.div_op[1] ? 32'h0000_0000 : 32'h8000_0000);

   assign op1_mag = (is_signed & bus.op1[31]) ? (32'h0 - bus.op1) : bus.op1;
   assign op2_mag = (is_signed & bus.op2[31]) ? (32'h0 - bus.op2) : bus.op2;

   // One restoring step: shift in the next dividend bit, try the subtract.
   // The remainder always stays below the divisor, so a set bit 32 of the
   // difference is exactly the borrow that says the divisor did not fit.
   assign shifted  = {rem, quo[31]};
   assign diff     = shifted - {1'b0, divisor};
   assign fits     = ~diff[32];
   assign rem_next = fits ? diff[31:0] : shifted[31:0];
   assign quo_next = {quo[30:0], fits};
   assign q_final  = neg_q ? (32'h0 - quo_next) : quo_next;
   assign r_final  = neg_r ? (32'h0 - rem_next) : rem_next;

   // State register; reset and flush both land in IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs; flush overrides every transition.
   always_comb begin
      state_next = state;
      busy_c     = 1'b0;
      valid_c    = 1'b0;
      case (state)
         IDLE: begin
            if (start_ok) begin
               busy_c     = 1'b1;
               state_next = special ? DONE : CALC;
            end
         end
         CALC: begin
            busy_c = 1'b1;
            if (count == 5'd31) begin
               state_next = DONE;
            end
         end
         DONE: begin
            valid_c    = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (bus.flush) begin
         state_next = IDLE;
      end
   end

   // Operand capture, iteration datapath and the held result register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count    <= 5'd0;
         divisor  <= 32'h0;
         quo      <= 32'h0;
         rem      <= 32'h0;
         is_rem   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         rd_q     <= 5'd0;
         result_q <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (start_ok) begin
                  count   <= 5'd0;
                  divisor <= op2_mag;
                  quo     <= op1_mag;
                  rem     <= 32'h0;
                  is_rem  <= bus.div_op[1];
                  neg_q   <= is_signed & (bus.op1[31] ^ bus.op2[31]);
                  neg_r   <= is_signed & bus.op1[31];
                  rd_q    <= bus.rd_addr;
                  if (special) begin
                     result_q <= special_result;
                  end
               end
            end
            CALC: begin
               if (!bus.flush) begin
                  quo   <= quo_next;
                  rem   <= rem_next;
                  count <= count + 5'd1;
                  if (count == 5'd31) begin
                     result_q <= is_rem ? r_final : q_final;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Reset gates the stall request so a start pending during reset cannot
   // hold the pipeline.
   assign bus.busy         = rst & busy_c;
   assign bus.result       = result_q;
   assign bus.result_valid = valid_c;
   assign bus.rd_wen_o     = valid_c;
   assign bus.rd_addr_o    = rd_q;

endmodule
